fp_mant_addsub_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined mantissa add/subtract unit for the IEEE754 datapath.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_mant_addsub_pipe.sv | 199 +++++++++++++++++++
 tb/tb_fp_mant_addsub_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point mantissa datapath.
//   fp_extw(mw) : width of the aligned operand plus carry (hidden + fraction + G/R/S + carry)
//   fp_ew(mw)   : width of the signed exponent adjustment reported after normalisation
//   GRS_*       : bit positions of guard/round/sticky inside a 3-bit grs field
//   eff_op_e    : effective operation (sign XOR of the operands)
package fp_pkg;

  localparam int GRS_G = 2;
  localparam int GRS_R = 1;
  localparam int GRS_S = 0;

  typedef enum logic {
    EFF_ADD = 1'b0,
    EFF_SUB = 1'b1
  } eff_op_e;

  function automatic int fp_extw(input int mw);
    return mw + 5;
  endfunction

  function automatic int fp_ew(input int mw);
    return $clog2(mw + 5) + 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
//   d   : input vector, MSB first
//   cnt : number of leading zeros; equals W when d is all zero
module fp_lzc #(
  parameter  int W  = 14,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);

  // Scan from LSB upward so the highest set bit wins.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (d[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_mant_addsub_pipe.sv
// Three-stage pipelined mantissa add/subtract with alignment and normalisation.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand beat handshake
//   moves                : exponent difference, A has the larger-or-equal exponent
//   am, bm, as, bs       : fractions (hidden 1 implied) and signs of A and B
//   out_valid / out_ready: result beat handshake
//   rm                   : normalised mantissa {hidden, fraction}
//   grs                  : guard, round, sticky after normalisation
//   rs                   : result sign (+0 on exact zero)
//   exp_adj              : signed exponent adjustment (+1 on carry, -lz otherwise)
//   zero                 : exact zero result
module fp_mant_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int MW  = 10,
  parameter  int SHW = 5,
  localparam int EW  = fp_ew(MW)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SHW-1:0]       moves,
  input  logic [MW-1:0]        am,
  input  logic [MW-1:0]        bm,
  input  logic                 as,
  input  logic                 bs,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MW:0]          rm,
  output logic [2:0]           grs,
  output logic                 rs,
  output logic signed [EW-1:0] exp_adj,
  output logic                 zero
);

  localparam int EXTW = fp_extw(MW);
  localparam int OPW  = EXTW - 1;
  localparam int BWW  = MW + 3;
  localparam int LZW  = $clog2(OPW + 1);

  // OR of the bits of v that fall below the shift amount.
  function automatic logic shifted_out_or(input logic [BWW-1:0] v, input logic [SHW-1:0] sh);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < BWW; i++) begin
      if (i < int'(sh)) acc |= v[i];
    end
    return acc;
  endfunction

  // The whole pipe freezes while the output beat is not taken.
  logic stall;
  logic en;
  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  logic vld_p0;
  logic vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      out_valid <= vld_p1;
    end
  end

  // ---- Stage 1: align B to A ----
  logic [BWW-1:0] bw;
  logic [BWW-1:0] bsh;
  logic           b_stk;

  always_comb begin
    bw = {1'b1, bm, 2'b00};
    if (int'(moves) >= BWW) begin
      bsh   = '0;
      b_stk = 1'b1;
    end else begin
      bsh   = bw >> moves;
      b_stk = shifted_out_or(bw, moves);
    end
  end

  logic [OPW-1:0] a_p0;
  logic [OPW-1:0] b_p0;
  logic           as_p0;
  logic           bs_p0;

  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      a_p0  <= {1'b1, am, 3'b000};
      b_p0  <= {bsh, b_stk};
      as_p0 <= as;
      bs_p0 <= bs;
    end
  end

  // ---- Stage 2: effective add/subtract ----
  eff_op_e        op_p0;
  logic [EXTW-1:0] sum_n;
  logic [EXTW-1:0] dif_n;
  logic [EXTW-1:0] rdif_n;
  logic [EXTW-1:0] r_n;
  logic            rs_n;
  logic            zero_n;

  assign op_p0 = eff_op_e'(as_p0 ^ bs_p0);

  always_comb begin
    sum_n  = {1'b0, a_p0} + {1'b0, b_p0};
    dif_n  = {1'b0, a_p0} - {1'b0, b_p0};
    rdif_n = {1'b0, b_p0} - {1'b0, a_p0};
    r_n    = sum_n;
    rs_n   = as_p0;
    if (op_p0 == EFF_SUB) begin
      // A borrow means |B| > |A|: take B-A and B's sign.
      if (dif_n[EXTW-1]) begin
        r_n  = rdif_n;
        rs_n = bs_p0;
      end else begin
        r_n  = dif_n;
      end
    end
    zero_n = (r_n == '0);
    if (zero_n) rs_n = 1'b0;
  end

  logic [EXTW-1:0] r_p1;
  logic            rs_p1;
  logic            zero_p1;

  always_ff @(posedge clk) begin
    if (en && vld_p0) begin
      r_p1    <= r_n;
      rs_p1   <= rs_n;
      zero_p1 <= zero_n;
    end
  end

  // ---- Stage 3: normalise ----
  logic [LZW-1:0]        lz;
  logic [OPW-1:0]        nsh;
  logic [MW:0]           n_rm;
  logic [2:0]            n_grs;
  logic signed [EW-1:0]  n_ea;

  fp_lzc #(.W(OPW)) u_lzc (
    .d   (r_p1[OPW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    nsh   = r_p1[OPW-1:0] << lz;
    n_rm  = '0;
    n_grs = '0;
    n_ea  = '0;
    if (zero_p1) begin
      n_rm  = '0;
      n_grs = '0;
      n_ea  = '0;
    end else if (r_p1[EXTW-1]) begin
      n_rm         = r_p1[EXTW-1:4];
      n_grs[GRS_G] = r_p1[3];
      n_grs[GRS_R] = r_p1[2];
      n_grs[GRS_S] = r_p1[1] | r_p1[0];
      n_ea         = EW'(1);
    end else begin
      n_rm         = nsh[OPW-1:3];
      n_grs[GRS_G] = nsh[2];
      n_grs[GRS_R] = nsh[1];
      // Keep the original sticky even after it has been shifted up.
      n_grs[GRS_S] = nsh[0] | r_p1[0];
      n_ea         = EW'(0) - EW'(lz);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rm      <= '0;
      grs     <= '0;
      rs      <= 1'b0;
      exp_adj <= '0;
      zero    <= 1'b0;
    end else if (en && vld_p1) begin
      rm      <= n_rm;
      grs     <= n_grs;
      rs      <= rs_p1;
      exp_adj <= n_ea;
      zero    <= zero_p1;
    end
  end

endmodule

// File: tb/tb_fp_mant_addsub_pipe.sv
module tb_fp_mant_addsub_pipe;

  localparam int MW  = 10;
  localparam int SHW = 5;
  localparam int EW  = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [SHW-1:0]       moves = '0;
  logic [MW-1:0]        am = '0;
  logic [MW-1:0]        bm = '0;
  logic                 as = 1'b0;
  logic                 bs = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [MW:0]          rm;
  logic [2:0]           grs;
  logic                 rs;
  logic signed [EW-1:0] exp_adj;
  logic                 zero;

  int checks = 0;
  int errors = 0;

  fp_mant_addsub_pipe #(.MW(MW), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .moves     (moves),
    .am        (am),
    .bm        (bm),
    .as        (as),
    .bs        (bs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rm        (rm),
    .grs       (grs),
    .rs        (rs),
    .exp_adj   (exp_adj),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        mv;
    logic [9:0]        a;
    logic [9:0]        b;
    logic              sa;
    logic              sb;
    logic [10:0]       r;
    logic [2:0]        g;
    logic              s;
    logic signed [4:0] e;
    logic              z;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [4:0] mv, input logic [9:0] a, input logic [9:0] b,
                              input logic sa, input logic sb, input logic [10:0] r,
                              input logic [2:0] g, input logic s, input logic signed [4:0] e,
                              input logic z);
    vec_t v;
    v.mv = mv; v.a = a; v.b = b; v.sa = sa; v.sb = sb;
    v.r = r; v.g = g; v.s = s; v.e = e; v.z = z;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    moves = v.mv; am = v.a; bm = v.b; as = v.sa; bs = v.sb;
    in_valid = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_latency", idx), n, 3);
    chk($sformatf("v%0d_rm", idx), 32'(rm), 32'(v.r));
    chk($sformatf("v%0d_grs", idx), 32'(grs), 32'(v.g));
    chk($sformatf("v%0d_rs", idx), 32'(rs), 32'(v.s));
    chk($sformatf("v%0d_exp_adj", idx), 32'(exp_adj), 32'(v.e));
    chk($sformatf("v%0d_zero", idx), 32'(zero), 32'(v.z));
  endtask

  initial begin
    //            moves  am       bm      as    bs    rm        grs     rs    exp_adj  zero
    vecs[0]  = mk(5'd0,  10'h000, 10'h000, 1'b0, 1'b0, 11'h400, 3'b000, 1'b0,  5'sd1,  1'b0);
    vecs[1]  = mk(5'd1,  10'h000, 10'h000, 1'b0, 1'b0, 11'h600, 3'b000, 1'b0,  5'sd0,  1'b0);
    vecs[2]  = mk(5'd0,  10'h155, 10'h155, 1'b0, 1'b1, 11'h000, 3'b000, 1'b0,  5'sd0,  1'b1);
    vecs[3]  = mk(5'd0,  10'h000, 10'h200, 1'b0, 1'b1, 11'h400, 3'b000, 1'b1, -5'sd1,  1'b0);
    vecs[4]  = mk(5'd20, 10'h3FF, 10'h000, 1'b0, 1'b0, 11'h7FF, 3'b001, 1'b0,  5'sd0,  1'b0);
    vecs[5]  = mk(5'd31, 10'h000, 10'h3FF, 1'b0, 1'b0, 11'h400, 3'b001, 1'b0,  5'sd0,  1'b0);
    vecs[6]  = mk(5'd3,  10'h000, 10'h001, 1'b0, 1'b0, 11'h480, 3'b001, 1'b0,  5'sd0,  1'b0);
    vecs[7]  = mk(5'd1,  10'h3FF, 10'h3FF, 1'b0, 1'b0, 11'h5FF, 3'b010, 1'b0,  5'sd1,  1'b0);
    vecs[8]  = mk(5'd0,  10'h000, 10'h000, 1'b1, 1'b1, 11'h400, 3'b000, 1'b1,  5'sd1,  1'b0);
    vecs[9]  = mk(5'd0,  10'h100, 10'h000, 1'b1, 1'b0, 11'h400, 3'b000, 1'b1, -5'sd2,  1'b0);
    vecs[10] = mk(5'd0,  10'h155, 10'h155, 1'b1, 1'b0, 11'h000, 3'b000, 1'b0,  5'sd0,  1'b1);
    vecs[11] = mk(5'd20, 10'h000, 10'h000, 1'b0, 1'b1, 11'h7FF, 3'b111, 1'b0, -5'sd1,  1'b0);
    vecs[12] = mk(5'd1,  10'h000, 10'h000, 1'b0, 1'b1, 11'h400, 3'b000, 1'b0, -5'sd1,  1'b0);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rm", 32'(rm), 32'd0);
    chk("rst_grs", 32'(grs), 32'd0);
    chk("rst_exp_adj", 32'(exp_adj), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_rs", 32'(rs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 13; i++) apply(vecs[i], i);

    // Backpressure: 4 beats, output held for 5 cycles
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin : drv
        int w;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          moves = 5'd20; am = 10'(k * 85); bm = 10'h000; as = 1'b0; bs = 1'b0;
          in_valid = 1'b1;
          w = 0;
          while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
          end
          if (w >= 50) chk("bp_drive_timeout", 32'(w), 32'd0);
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : col
        int w;
        int got;
        w = 0;
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
          chk($sformatf("bp_stall_in_ready_%0d", c), 32'(in_ready), 32'd0);
          chk($sformatf("bp_stall_rm_%0d", c), 32'(rm), 32'h400);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (out_valid) begin
            if (got < 4) begin
              chk($sformatf("bp_rm_%0d", got), 32'(rm), 32'({1'b1, 10'(got * 85)}));
              chk($sformatf("bp_grs_%0d", got), 32'(grs), 32'd1);
            end
            got++;
          end
        end
        chk("bp_count", 32'(got), 32'd4);
      end
    join

    // Asynchronous reset with beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    moves = 5'd0; am = 10'h000; bm = 10'h000; as = 1'b0; bs = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    am = 10'h0AA;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    begin
      int w;
      w = 0;
      while (!out_valid && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    chk("rstf_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstf_out_valid", 32'(out_valid), 32'd0);
    chk("rstf_rm", 32'(rm), 32'd0);
    chk("rstf_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      chk("rstf_no_stale", 32'(stale), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
